alu_bit_serial_sequencer: RTL and testbench

Upstream controller for the team's 1-bit combinational ALU (3-bit opcode; ports a, b, res, cry). It accepts a WIDTH-bit operand pair and an opcode through a valid/ready request port. It then streams the operands LSB-first into the 1-bit ALU, one bit per clock, and collects res/cry into WIDTH-bit result and carry words. The finished words are presented on a valid/ready response port and held until consumed.

---
 rtl/alu_bit_serial_sequencer.sv | 139 +++++++++++++
 tb/tb_alu_bit_serial_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_bit_serial_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_bit_serial_sequencer
//  Function : Feeds a WIDTH-bit operand pair LSB-first through an external
//             1-bit combinational ALU and collects its result and carry
//             bits into WIDTH-bit words, returned on a valid/ready port.
//  Revision : 1.0 - initial release
// ============================================================================
module alu_bit_serial_sequencer #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    // request port
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    // 1-bit ALU interface
    output logic [2:0]       alu_opcode,
    output logic             alu_a,
    output logic             alu_b,
    input  logic             alu_res,
    input  logic             alu_cry,
    // response port
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [WIDTH-1:0] out_cry
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    // Counter value at which the MSB is on the ALU inputs
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_res_sr;
    logic [WIDTH-1:0]   r_cry_sr;
    logic [WIDTH-1:0]   r_out_res;
    logic [WIDTH-1:0]   r_out_cry;
    logic               w_accept;
    logic               w_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode and handshake / ALU drive outputs
    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        alu_opcode = 3'd0;
        alu_a      = 1'b0;
        alu_b      = 1'b0;
        w_accept   = 1'b0;
        w_last     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                alu_opcode = r_op;
                alu_a      = r_a_sr[0];
                alu_b      = r_b_sr[0];
                if (r_cnt == c_last) begin
                    w_last = 1'b1;
                    w_next = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, bit shifting and result collection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_op      <= 3'd0;
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_res_sr  <= '0;
            r_cry_sr  <= '0;
            r_out_res <= '0;
            r_out_cry <= '0;
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_op   <= in_opcode;
            r_a_sr <= in_a;
            r_b_sr <= in_b;
        end else if (r_state == S_RUN) begin
            r_res_sr <= {alu_res, r_res_sr[WIDTH-1:1]};
            r_cry_sr <= {alu_cry, r_cry_sr[WIDTH-1:1]};
            r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
            r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
            r_cnt    <= r_cnt + CNT_W'(1);
            // Publish the finished words only on the MSB cycle so the
            // response stays put through the next operation's RUN phase.
            if (w_last) begin
                r_out_res <= {alu_res, r_res_sr[WIDTH-1:1]};
                r_out_cry <= {alu_cry, r_cry_sr[WIDTH-1:1]};
            end
        end
    end

    assign out_res = r_out_res;
    assign out_cry = r_out_cry;

endmodule
`default_nettype wire

// File: tb/tb_alu_bit_serial_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_bit_serial_sequencer
//  Function : Directed, table-driven self-checking bench for the bit-serial
//             ALU sequencer, with a behavioural 1-bit ALU attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_bit_serial_sequencer;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       alu_opcode;
    logic             alu_a;
    logic             alu_b;
    logic             alu_res;
    logic             alu_cry;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_res;
    logic [WIDTH-1:0] out_cry;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        int         bp;
        logic [7:0] exp_res;
        logic [7:0] exp_cry;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    alu_bit_serial_sequencer #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .alu_opcode (alu_opcode),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_res    (alu_res),
        .alu_cry    (alu_cry),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_cry    (out_cry)
    );

    // Behavioural stand-in for the 1-bit combinational ALU
    always_comb begin
        alu_res = 1'b0;
        alu_cry = 1'b0;
        case (alu_opcode)
            3'd0: alu_res = alu_a | alu_b;
            3'd1: alu_res = alu_a & alu_b;
            3'd2: alu_res = ~alu_a;
            3'd3: alu_res = ~(alu_a | alu_b);
            3'd4: alu_res = ~(alu_a & alu_b);
            3'd5: alu_res = alu_a;
            3'd6: begin
                alu_res = alu_a ^ alu_b;
                alu_cry = alu_a & alu_b;
            end
            default: alu_res = alu_a ^ alu_b;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One full request/response transaction; bp = cycles of out_ready=0
    // after out_valid rises.
    task automatic transact(input int idx, input vec_t v);
        int         n;
        logic [7:0] sa;
        logic [7:0] sb;
        bit         op_bad;
        bit         early;
        bit         rdy_seen;
        bit         hold_bad;
        string      t;
        t = $sformatf("v%0d", idx);
        out_ready = (v.bp == 0);
        @(negedge clk);
        in_valid  = 1'b1;
        in_opcode = v.op;
        in_a      = v.a;
        in_b      = v.b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({t, "_accept_wait"}, 32'(n < 50), 32'd1);
        @(negedge clk);
        // Scramble the request bus: the operands must already be latched.
        in_valid  = 1'b0;
        in_opcode = 3'($urandom);
        in_a      = 8'($urandom);
        in_b      = 8'($urandom);
        sa = 8'h00; sb = 8'h00; op_bad = 1'b0; early = 1'b0; rdy_seen = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            sa[i] = alu_a;
            sb[i] = alu_b;
            if (alu_opcode !== v.op) op_bad = 1'b1;
            if (out_valid)           early  = 1'b1;
            if (in_ready)            rdy_seen = 1'b1;
            @(negedge clk);
        end
        check({t, "_alu_a_stream"}, 32'(sa), 32'(v.a));
        check({t, "_alu_b_stream"}, 32'(sb), 32'(v.b));
        check({t, "_alu_opcode"},   32'(op_bad), 32'd0);
        check({t, "_early_valid"},  32'(early), 32'd0);
        check({t, "_ready_in_run"}, 32'(rdy_seen), 32'd0);
        check({t, "_latency_valid"}, 32'(out_valid), 32'd1);
        hold_bad = 1'b0;
        for (int j = 0; j < v.bp; j++) begin
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                out_res !== v.exp_res || out_cry !== v.exp_cry) hold_bad = 1'b1;
            @(negedge clk);
        end
        check({t, "_hold_stable"}, 32'(hold_bad), 32'd0);
        check({t, "_out_valid"}, 32'(out_valid), 32'd1);
        check({t, "_out_res"}, 32'(out_res), 32'(v.exp_res));
        check({t, "_out_cry"}, 32'(out_cry), 32'(v.exp_cry));
        out_ready = 1'b1;
        @(negedge clk);
        check({t, "_ready_after_hs"}, 32'(in_ready), 32'd1);
        check({t, "_valid_after_hs"}, 32'(out_valid), 32'd0);
        check({t, "_res_kept"}, 32'(out_res), 32'(v.exp_res));
    endtask

    initial begin
        int n;
        bit rdy_seen;
        bit v_seen;

        // op, a, b, backpressure cycles, expected res, expected cry
        vecs[0]  = '{3'd1, 8'hCA, 8'h0F, 0, 8'h0A, 8'h00};
        vecs[1]  = '{3'd6, 8'hF0, 8'h3C, 0, 8'hCC, 8'h30};
        vecs[2]  = '{3'd2, 8'h55, 8'hFF, 0, 8'hAA, 8'h00};
        vecs[3]  = '{3'd7, 8'h96, 8'h69, 5, 8'hFF, 8'h00};
        vecs[4]  = '{3'd0, 8'hA5, 8'h3C, 0, 8'hBD, 8'h00};
        vecs[5]  = '{3'd1, 8'hA5, 8'h3C, 0, 8'h24, 8'h00};
        vecs[6]  = '{3'd2, 8'hA5, 8'h3C, 0, 8'h5A, 8'h00};
        vecs[7]  = '{3'd3, 8'hA5, 8'h3C, 0, 8'h42, 8'h00};
        vecs[8]  = '{3'd4, 8'hA5, 8'h3C, 0, 8'hDB, 8'h00};
        vecs[9]  = '{3'd5, 8'hA5, 8'h3C, 0, 8'hA5, 8'h00};
        vecs[10] = '{3'd6, 8'hA5, 8'h3C, 0, 8'h99, 8'h24};
        vecs[11] = '{3'd7, 8'hA5, 8'h3C, 0, 8'h99, 8'h00};

        rst = 1'b1; in_valid = 1'b0; in_opcode = 3'd0; in_a = '0; in_b = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready",  32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_res",   32'(out_res), 32'd0);
        check("rst_out_cry",   32'(out_cry), 32'd0);
        check("rst_alu_drive", {29'd0, alu_opcode} | 32'(alu_a) | 32'(alu_b), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            transact(i, vecs[i]);
        end

        // Request held during RUN: second request waits for IDLE
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_opcode = 3'd1; in_a = 8'hCA; in_b = 8'h0F;
        @(negedge clk);
        check("busy_first_accept", 32'(in_ready), 32'd0);
        in_opcode = 3'd0; in_a = 8'hA5; in_b = 8'h3C;
        n = 0; rdy_seen = 1'b0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
            if (in_ready) rdy_seen = 1'b1;
        end
        check("busy_latency1", 32'(n), 32'd8);
        check("busy_no_accept", 32'(rdy_seen), 32'd0);
        check("busy_res1", 32'(out_res), 32'h0A);
        @(negedge clk);
        check("busy_idle_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        check("busy_second_accept", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("busy_latency2", 32'(n), 32'd8);
        check("busy_res2", 32'(out_res), 32'hBD);
        check("busy_cry2", 32'(out_cry), 32'h00);
        @(negedge clk);

        // Reset on the third RUN cycle aborts without a response
        @(negedge clk);
        in_valid = 1'b1; in_opcode = 3'd6; in_a = 8'hFF; in_b = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_alu_a_live", 32'(alu_a), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_in_ready",  32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_out_res",   32'(out_res), 32'd0);
        check("abort_out_cry",   32'(out_cry), 32'd0);
        check("abort_alu_ab",    32'(alu_a) | 32'(alu_b), 32'd0);
        rst = 1'b0;
        v_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) v_seen = 1'b1;
        end
        check("abort_no_response", 32'(v_seen), 32'd0);

        // Sequencer still usable after the abort
        transact(12, vecs[1]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
